// File: rtl/elevator_button_conditioner_if.sv
// ============================================================================
// Module      : elevator_button_conditioner_if
// Description : Button, floor-status and conditioned pulse/lamp bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface elevator_button_conditioner_if;
  logic [7:1] raw_btup;
  logic [8:2] raw_btdn;
  logic [8:1] raw_in_bt;
  logic [8:1] floor;
  logic       door_open;
  logic [7:1] btup;
  logic [8:2] btdn;
  logic [8:1] in_bt_floor;
  logic [7:1] lamp_up;
  logic [8:2] lamp_dn;
  logic [8:1] lamp_in;

  modport master (
    output raw_btup, raw_btdn, raw_in_bt, floor, door_open,
    input  btup, btdn, in_bt_floor, lamp_up, lamp_dn, lamp_in
  );

  modport slave (
    input  raw_btup, raw_btdn, raw_in_bt, floor, door_open,
    output btup, btdn, in_bt_floor, lamp_up, lamp_dn, lamp_in
  );
endinterface

`default_nettype wire

// File: rtl/elevator_button_conditioner.sv
// ============================================================================
// Module      : elevator_button_conditioner
// Description : Synchronise and debounce 22 elevator buttons into one-clock
//               press pulses and hold call lamps until the door opens there.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_button_conditioner #(
  parameter int PRESCALE    = 1000,
  parameter int DEB_TICKS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input wire logic                            clk,
  input wire logic                            rst,
  elevator_button_conditioner_if.slave        bus
);

  localparam int c_nb = 22;
  localparam int c_pw = $clog2(PRESCALE);
  localparam int c_cw = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [c_pw-1:0] c_presc_last = c_pw'(PRESCALE - 1);
  localparam logic [c_cw-1:0] c_cnt_last   = c_cw'(DEB_TICKS - 1);

  // Channel packing: [6:0] hall up (floors 1..7), [13:7] hall down
  // (floors 2..8), [21:14] cabin (floors 1..8).
  logic [c_nb-1:0]                   w_raw;
  logic [c_nb-1:0]                   w_sync;
  logic [c_nb-1:0]                   w_clr;
  logic                              w_tick;
  logic [SYNC_STAGES-1:0][c_nb-1:0]  r_sync;
  logic [c_pw-1:0]                   r_presc;
  logic [c_nb-1:0]                   r_stable;
  logic [c_nb-1:0]                   r_pulse;
  logic [c_nb-1:0]                   r_lamp;
  logic [c_cw-1:0]                   r_cnt [c_nb];

  assign w_raw  = {bus.raw_in_bt, bus.raw_btdn, bus.raw_btup};
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_presc == c_presc_last);
  assign w_clr  = bus.door_open ? {bus.floor[8:1], bus.floor[8:2], bus.floor[7:1]}
                                : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_presc <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw};
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // A new level is accepted only after DEB_TICKS consecutive ticks of mismatch;
  // any clock where the level agrees restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= '0;
      r_pulse  <= '0;
      r_lamp   <= '0;
      for (int i = 0; i < c_nb; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_nb; i++) begin
        r_pulse[i] <= 1'b0;
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == c_cnt_last) begin
            r_stable[i] <= w_sync[i];
            r_cnt[i]    <= '0;
            r_pulse[i]  <= w_sync[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
      // Clear has priority so a call made at an open door never lights.
      r_lamp <= (r_lamp | r_pulse) & ~w_clr;
    end
  end

  assign bus.btup        = r_pulse[6:0];
  assign bus.btdn        = r_pulse[13:7];
  assign bus.in_bt_floor = r_pulse[21:14];
  assign bus.lamp_up     = r_lamp[6:0];
  assign bus.lamp_dn     = r_lamp[13:7];
  assign bus.lamp_in     = r_lamp[21:14];

endmodule

`default_nettype wire

// File: tb/tb_elevator_button_conditioner.sv
// ============================================================================
// Module      : tb_elevator_button_conditioner
// Description : Directed self-checking bench with expected-pulse scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_button_conditioner;

  localparam int c_lat_min = 11;
  localparam int c_lat_max = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [21:0] exp_q [$];

  elevator_button_conditioner_if bus ();

  elevator_button_conditioner #(
    .PRESCALE    (4),
    .DEB_TICKS   (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] pulse_vec();
    return {bus.in_bt_floor, bus.btdn, bus.btup};
  endfunction

  function automatic logic [21:0] lamp_vec();
    return {bus.lamp_in, bus.lamp_dn, bus.lamp_up};
  endfunction

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Pops the next expected pulse vector and waits (bounded) for the DUT to pulse.
  task automatic await_pulse(input string tag);
    logic [21:0] exp;
    logic [21:0] got;
    int n;
    exp = exp_q.pop_front();
    got = '0;
    n   = 0;
    while (n < c_lat_max + 5 && got == '0) begin
      @(negedge clk);
      n++;
      got = pulse_vec();
    end
    check({tag, " pulse"}, got, exp);
    checks++;
    assert (n >= c_lat_min && n <= c_lat_max) else begin
      errors++;
      $error("FAIL %s latency: observed %0d expected %0d..%0d", tag, n, c_lat_min, c_lat_max);
    end
  endtask

  task automatic hold_quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (pulse_vec() != '0) hits++;
    end
    check({tag, " quiet"}, 22'(hits), 22'd0);
  endtask

  initial begin
    int hits;
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.raw_btup  = '0;
    bus.raw_btdn  = '0;
    bus.raw_in_bt = '0;
    bus.floor     = '0;
    bus.door_open = 1'b0;

    @(negedge clk);
    check("reset pulses", pulse_vec(), 22'd0);
    check("reset lamps", lamp_vec(), 22'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Cabin 5 held 40 clks: one pulse, lamp latches.
    bus.raw_in_bt[5] = 1'b1;
    exp_q.push_back(22'h1 << 18);
    await_pulse("in5");
    @(negedge clk);
    check("in5 single", pulse_vec(), 22'd0);
    check("in5 lamp", lamp_vec(), 22'h1 << 18);
    hold_quiet("in5 hold", 26);
    bus.raw_in_bt[5] = 1'b0;
    hold_quiet("in5 release", 18);

    // Up 3 bouncing 3 high / 3 low never settles.
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      bus.raw_btup[3] = ((i % 6) < 3);
      @(negedge clk);
      if (pulse_vec() != '0) hits++;
    end
    bus.raw_btup[3] = 1'b0;
    check("bounce pulses", 22'(hits), 22'd0);
    hold_quiet("bounce tail", 16);
    check("bounce lamp_up", 22'(bus.lamp_up), 22'd0);

    // Down 6 lamp, then door handling across floor vectors.
    bus.raw_btdn[6] = 1'b1;
    exp_q.push_back(22'h1 << 11);
    await_pulse("dn6");
    bus.raw_btdn[6] = 1'b0;
    hold_quiet("dn6 release", 18);
    check("dn6 lamps", lamp_vec(), (22'h1 << 18) | (22'h1 << 11));
    bus.door_open = 1'b1;
    bus.floor     = 8'b0000_0000;
    @(negedge clk);
    check("floor zero", lamp_vec(), (22'h1 << 18) | (22'h1 << 11));
    bus.floor = 8'b0010_0000;
    @(negedge clk);
    check("floor6 clear", lamp_vec(), 22'h1 << 18);
    bus.floor = 8'b1001_0000;
    @(negedge clk);
    check("multihot clear", lamp_vec(), 22'd0);
    bus.door_open = 1'b0;
    bus.floor     = '0;

    // Up 2 pulse while door open at floor 2: pulse yes, lamp no.
    bus.door_open   = 1'b1;
    bus.floor       = 8'b0000_0010;
    bus.raw_btup[2] = 1'b1;
    exp_q.push_back(22'h1 << 1);
    await_pulse("up2 collide");
    @(negedge clk);
    check("up2 lamp", lamp_vec(), 22'd0);
    bus.raw_btup[2] = 1'b0;
    hold_quiet("up2 release", 18);
    bus.door_open = 1'b0;
    bus.floor     = '0;

    // Down 8 held through a mid-debounce reset.
    bus.raw_btdn[8] = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst mid pulses 1", pulse_vec(), 22'd0);
    check("rst mid lamps 1", lamp_vec(), 22'd0);
    @(negedge clk);
    check("rst mid pulses 2", pulse_vec(), 22'd0);
    check("rst mid lamps 2", lamp_vec(), 22'd0);
    rst = 1'b1;
    exp_q.push_back(22'h1 << 13);
    await_pulse("dn8 after rst");
    hold_quiet("dn8 hold", 10);
    check("dn8 lamp", lamp_vec(), 22'h1 << 13);
    bus.raw_btdn[8] = 1'b0;
    hold_quiet("dn8 release", 18);

    // Every button at once.
    bus.raw_btup  = '1;
    bus.raw_btdn  = '1;
    bus.raw_in_bt = '1;
    exp_q.push_back(22'h3F_FFFF);
    await_pulse("all");
    @(negedge clk);
    check("all single", pulse_vec(), 22'd0);
    check("all lamps", lamp_vec(), 22'h3F_FFFF);
    check("queue drained", 22'(exp_q.size()), 22'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
